// File: rtl/sample_playback_buffer_pkg.sv
// Shared audio types for the playback path: sample type, playback state and
// the saturating counter helper used by the underrun statistics.
package fpga_template_pkg;
  localparam int AUDIO_W = 24;

  typedef logic signed [AUDIO_W-1:0] sample_t;

  typedef enum logic [1:0] {
    PB_PREFILL = 2'd0,
    PB_STREAM  = 2'd1
  } pb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/sample_playback_buffer_if.sv
// Producer/transmitter side bundle of the playback buffer. The slave modport is
// the buffer itself; the master modport is the surrounding logic.
interface sample_playback_buffer_if #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256
);
  localparam int LVL_W = $clog2(DEPTH + 1) + 1;

  logic [DATA_W-1:0] wr_data_i;
  logic              wr_valid_i;
  logic              wr_ready_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic              buffer_ready_o;
  logic [LVL_W-1:0]  level_o;
  logic              underrun_o;
  logic [15:0]       underrun_cnt_o;

  modport slave (
    input  wr_data_i, wr_valid_i, rd_ready_i,
    output wr_ready_o, rd_data_o, rd_valid_o, buffer_ready_o, level_o,
           underrun_o, underrun_cnt_o
  );

  modport master (
    output wr_data_i, wr_valid_i, rd_ready_i,
    input  wr_ready_o, rd_data_o, rd_valid_o, buffer_ready_o, level_o,
           underrun_o, underrun_cnt_o
  );
endinterface

// File: rtl/sample_playback_buffer_ram.sv
// Simple dual-port sample store: one write port, one registered read port,
// no reset so it maps onto block RAM.
module sample_buffer_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sample_playback_buffer.sv
// Circular sample FIFO feeding the I2S transmitter: RAM store plus a show-ahead
// output register, prefill hysteresis for buffer_ready and underrun tracking.
module sample_playback_buffer
  import fpga_template_pkg::*;
#(
  parameter int DATA_W  = AUDIO_W,
  parameter int DEPTH   = 256,
  parameter int PREFILL = 32
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  input logic                     flush_i,
  sample_playback_buffer_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1) + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_PRE = LVL_W'(PREFILL);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

  logic [AW:0]        r_wptr, r_rptr;
  logic               r_inflight, r_rd_valid;
  logic [DATA_W-1:0]  r_rd_data;
  logic [LVL_W-1:0]   r_level;
  pb_state_e          r_state;
  logic               r_buf_ready, r_underrun;
  logic [15:0]        r_urun_cnt;

  logic               w_wr_ready, w_wr_acc, w_rd_acc, w_ram_empty, w_fetch;
  logic [DATA_W-1:0]  w_ram_q;

  // level counts RAM + in-flight read + output register, so it alone bounds capacity
  assign w_wr_ready  = r_level < LVL_MAX;
  assign w_wr_acc    = bus.wr_valid_i && w_wr_ready && !flush_i;
  assign w_rd_acc    = r_rd_valid && bus.rd_ready_i && !flush_i;
  assign w_ram_empty = r_wptr == r_rptr;
  // only one RAM read in flight; it always lands in a free output register
  assign w_fetch     = !w_ram_empty && !r_inflight && (!r_rd_valid || w_rd_acc) && !flush_i;

  sample_buffer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .i_clk  (clk_i),
    .i_we   (w_wr_acc),
    .i_waddr(r_wptr[AW-1:0]),
    .i_wdata(bus.wr_data_i),
    .i_re   (w_fetch),
    .i_raddr(r_rptr[AW-1:0]),
    .o_rdata(w_ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_level    <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_fetch)  r_rptr <= r_rptr + PTR_ONE;
      r_inflight <= w_fetch;
      if (r_inflight) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_ram_q;
      end else if (w_rd_acc) begin
        r_rd_valid <= 1'b0;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= PB_PREFILL;
      r_buf_ready <= 1'b0;
      r_underrun  <= 1'b0;
      r_urun_cnt  <= '0;
    end else if (flush_i) begin
      r_state     <= PB_PREFILL;
      r_buf_ready <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        PB_PREFILL: if (r_level >= LVL_PRE) begin
          r_state     <= PB_STREAM;
          r_buf_ready <= 1'b1;
        end
        PB_STREAM: if (r_level == '0) begin
          r_state     <= PB_PREFILL;
          r_buf_ready <= 1'b0;
          r_underrun  <= 1'b1;
          r_urun_cnt  <= sat_inc16(r_urun_cnt);
        end
        default: begin
          r_state     <= PB_PREFILL;
          r_buf_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready_o     = w_wr_ready;
  assign bus.rd_data_o      = r_rd_data;
  assign bus.rd_valid_o     = r_rd_valid;
  assign bus.buffer_ready_o = r_buf_ready;
  assign bus.level_o        = r_level;
  assign bus.underrun_o     = r_underrun;
  assign bus.underrun_cnt_o = r_urun_cnt;
endmodule

// File: doc/sample_playback_buffer.md
Name: sample_playback_buffer

Overview:
- Circular sample FIFO directly upstream of the I2S 24-bit transmitter.
- Accepts signed 24-bit audio samples from the DSP/producer over a valid/ready interface.
- Holds them in block RAM and presents them to the transmitter through a registered show-ahead valid/ready port.
- Generates the transmitter's buffer-ready start condition with prefill hysteresis, and flags underruns.

Parameters:
- DATA_W, 24, sample width in bits (signed two's complement, passed through unchanged).
- DEPTH, 256, storage entries excluding the output register; power of two, at least 4.
- PREFILL, 32, level at which streaming starts; 1 <= PREFILL <= DEPTH.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; synchronous, active-low.
- flush_i  in  1  synchronous clear of contents and streaming state.
- wr_data_i  in  DATA_W  producer sample.
- wr_valid_i  in  1  producer sample valid.
- wr_ready_o  out  1  buffer can accept a sample.
- rd_data_o  out  DATA_W  sample to transmitter (connects to ram_data_i).
- rd_valid_o  out  1  rd_data_o holds a sample (connects to ram_valid_i).
- rd_ready_i  in  1  transmitter accepts sample (from ram_ready_o).
- buffer_ready_o  out  1  streaming enabled (to buffer_ready_i).
- level_o  out  $clog2(DEPTH+1)+1  entries held, including output register.
- underrun_o  out  1  one-cycle pulse on underrun.
- underrun_cnt_o  out  16  saturating underrun count.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) values: wr_ready_o=1, rd_valid_o=0, rd_data_o=0, buffer_ready_o=0, level_o=0, underrun_o=0, underrun_cnt_o=0. Pointers and state return to PREFILL. RAM contents are don't-care.
- Write handshake:
  - A write is accepted when wr_valid_i && wr_ready_o.
  - wr_ready_o = (level < DEPTH+1), computed from registered state.
  - When full, a write is not accepted even if a read occurs in the same cycle.
- Read handshake:
  - Output register is show-ahead. A sample leaves when rd_valid_o && rd_ready_i.
  - rd_data_o is stable while rd_valid_o=1 and not consumed.
  - Refill: after a read, the next sample appears in the output register one cycle later if the RAM is non-empty. Equivalently, rd_valid_o drops for at most one cycle between back-to-back reads. The transmitter reads at most once per word select, so this is acceptable.
- Latency: a write into an empty buffer (accepted at edge N) gives rd_valid_o=1 after edge N+2 (RAM write, then RAM read into the output register).
- level_o: +1 per accepted write, -1 per accepted read, unchanged when both occur. Never exceeds DEPTH+1.
- Pointers: wrap modulo DEPTH, with an extra bit to distinguish full from empty.
- State machine (registered):
  - PREFILL: buffer_ready_o=0. Go to STREAM when level >= PREFILL; buffer_ready_o rises on the following edge.
  - STREAM: buffer_ready_o=1. Go to PREFILL when level reaches 0. buffer_ready_o falls the same edge the state changes.
  - On STREAM->PREFILL, underrun_o pulses for one cycle and underrun_cnt_o increments, saturating at 16'hFFFF.
  - In PREFILL, an empty buffer is not an underrun.
- Data ordering: strict FIFO. There is no sample modification, and the sign is preserved bit-exactly.
- flush_i:
  - Clears pointers, level, output register and rd_valid_o, and forces PREFILL with buffer_ready_o=0.
  - No underrun pulse is generated, and underrun_cnt_o is preserved.
  - Writes and reads in the flush cycle are discarded.
- Reset mid-operation: identical to flush, and additionally clears underrun_cnt_o.
- Priority: rst_ni > flush_i > normal operation.

Decomposition:
- Shared package fpga_template_pkg:
  - AUDIO_W = 24.
  - typedef of the signed audio sample.
  - typedef enum of the playback state {PB_PREFILL, PB_STREAM} (2-bit encoding).
- Sub-module sample_buffer_ram: simple dual-port RAM with one write port and one registered read port, inferred as block RAM and parameterised on DATA_W and DEPTH.
- Top-level contains pointers, level counter, output register control and the state machine.

Test Plan:
- Prefill: PREFILL=32. Write 31 samples -> buffer_ready_o stays 0. Write the 32nd -> buffer_ready_o=1 one cycle after level_o=32.
- Ordering/sign: write 24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h000001. Read with rd_ready_i pulses -> rd_data_o returns the same sequence bit-exact, and level_o returns to 0.
- Full: DEPTH=4. Write continuously -> wr_ready_o=0 at level_o=5. A simultaneous read and write at full -> level_o=4 and the write is not accepted.
- Underrun: stream 32 samples, stop writing, keep reading -> at level 0, underrun_o pulses once, underrun_cnt_o=1, buffer_ready_o=0. Resume writes -> streaming restarts only at level 32.
- Flush: level 20 in STREAM, assert flush_i one cycle -> level_o=0, rd_valid_o=0, buffer_ready_o=0, no underrun_o pulse, underrun_cnt_o unchanged.
- Wrap-around: DEPTH=4, PREFILL=2. Stream 1000 incrementing samples with random producer and consumer stalls -> output is in order with no loss or duplication.
